// File: rtl/tpu_ctrl_pkg.sv
// rtl/tpu_ctrl_pkg.sv - shared sequencer state encoding, stage IDs and default sizing
package tpu_ctrl_pkg;

   localparam int DEF_SYS_ARR_DIM  = 16;
   localparam int DEF_ADDR_W       = 16;
   localparam int DEF_MAX_OUT_ROWS = 128;
   localparam int DEF_MAX_OUT_COLS = 128;
   localparam int DEF_MAX_K_TILES  = 8;

   localparam int DEF_DIM_SHIFT = $clog2(DEF_SYS_ARR_DIM);
   localparam int DEF_COL_W     = $clog2(DEF_MAX_OUT_COLS / DEF_SYS_ARR_DIM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_LOAD,
      S_W_XFER,
      S_CALC,
      S_DRAIN,
      S_FINISH
   } seq_state_t;

   typedef enum logic [1:0] {
      STG_W_MEM_FIFO,
      STG_W_FIFO_ARR,
      STG_DATA_CALC
   } stage_id_t;

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - col/k tile counters and per-tile address / accumulator index generation
module tile_addr_gen
   import tpu_ctrl_pkg::*;
#(
   parameter int SYS_ARR_DIM = DEF_SYS_ARR_DIM,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int ROWS_W      = 8,
   parameter int CT_W        = 4,
   parameter int KT_W        = 4,
   parameter int COL_W       = DEF_COL_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   input  logic [ROWS_W-1:0] num_rows,
   input  logic [CT_W-1:0]   num_col_tiles,
   input  logic [KT_W-1:0]   num_k_tiles,
   input  logic [ADDR_W-1:0] base_weight,
   input  logic [ADDR_W-1:0] base_data,
   output logic [ADDR_W-1:0] next_weight_addr,
   output logic [ADDR_W-1:0] cur_data_addr,
   output logic [COL_W-1:0]  cur_col,
   output logic              cur_add,
   output logic              has_next
);

   localparam int DIM_SHIFT = $clog2(SYS_ARR_DIM);

   logic [CT_W-1:0]   col_idx;
   logic [CT_W-1:0]   next_col;
   logic [KT_W-1:0]   k_idx;
   logic [KT_W-1:0]   next_k;
   logic              last_col;
   logic              last_k;
   logic [ADDR_W-1:0] col_stride;

   // k is the inner loop: it wraps to 0 and carries into col
   assign last_k   = (k_idx == num_k_tiles - KT_W'(1));
   assign last_col = (col_idx == num_col_tiles - CT_W'(1));
   assign has_next = !(last_col && last_k);
   assign next_k   = last_k ? '0 : k_idx + KT_W'(1);
   assign next_col = last_k ? col_idx + CT_W'(1) : col_idx;

   // weight tiles are stored k-major, one row of col tiles per k step
   assign col_stride       = ADDR_W'(num_col_tiles) << DIM_SHIFT;
   assign next_weight_addr = base_weight + ADDR_W'(next_k) * col_stride
                             + (ADDR_W'(next_col) << DIM_SHIFT);
   assign cur_data_addr    = base_data + ADDR_W'(k_idx) * ADDR_W'(num_rows);
   assign cur_col          = COL_W'(col_idx);
   assign cur_add          = (k_idx != '0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         col_idx <= '0;
         k_idx   <= '0;
      end else if (advance) begin
         k_idx   <= next_k;
         col_idx <= next_col;
      end
   end

endmodule

// File: rtl/master_tile_sequencer.sv
// rtl/master_tile_sequencer.sv - tiled matmul sequencer driving weight load, weight transfer and calc stages
module master_tile_sequencer
   import tpu_ctrl_pkg::*;
#(
   parameter int SYS_ARR_DIM  = DEF_SYS_ARR_DIM,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
   parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
   parameter int MAX_K_TILES  = DEF_MAX_K_TILES
)(
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start,
   input  logic                                          prefetch,
   input  logic [$clog2(MAX_OUT_ROWS):0]                 num_rows,
   input  logic [$clog2(MAX_OUT_COLS/SYS_ARR_DIM):0]     num_col_tiles,
   input  logic [$clog2(MAX_K_TILES):0]                  num_k_tiles,
   input  logic [ADDR_W-1:0]                             base_weight,
   input  logic [ADDR_W-1:0]                             base_data,
   output logic                                          weight_mem_fifo_en,
   input  logic                                          weight_mem_fifo_done,
   output logic                                          weight_fifo_arr_en,
   input  logic                                          weight_fifo_arr_done,
   output logic                                          data_mem_calc_en,
   input  logic                                          data_mem_calc_done,
   output logic [ADDR_W-1:0]                             weight_addr,
   output logic [ADDR_W-1:0]                             data_addr,
   output logic [$clog2(MAX_OUT_ROWS):0]                 calc_num_rows,
   output logic [$clog2(MAX_OUT_COLS/SYS_ARR_DIM)-1:0]   accum_submat_col,
   output logic                                          accum_add,
   output logic                                          busy,
   output logic                                          done
);

   localparam int ROWS_W = $clog2(MAX_OUT_ROWS) + 1;
   localparam int CT_W   = $clog2(MAX_OUT_COLS / SYS_ARR_DIM) + 1;
   localparam int KT_W   = $clog2(MAX_K_TILES) + 1;
   localparam int COL_W  = $clog2(MAX_OUT_COLS / SYS_ARR_DIM);

   seq_state_t        state;
   logic              cfg_prefetch;
   logic [CT_W-1:0]   cfg_col_tiles;
   logic [KT_W-1:0]   cfg_k_tiles;
   logic [ADDR_W-1:0] cfg_base_weight;
   logic [ADDR_W-1:0] cfg_base_data;
   logic              pf_issued;
   logic              pf_done;

   logic              gen_clear;
   logic              advance;
   logic              pf_ack;
   logic              counts_ok;
   logic [ADDR_W-1:0] next_weight_addr;
   logic [ADDR_W-1:0] cur_data_addr;
   logic [COL_W-1:0]  cur_col;
   logic              cur_add;
   logic              has_next;

   assign gen_clear = (state == S_IDLE) && start;
   assign advance   = (state == S_CALC) && data_mem_calc_en && data_mem_calc_done;
   assign pf_ack    = (state == S_CALC) && weight_mem_fifo_en && weight_mem_fifo_done;
   assign counts_ok = (num_rows != '0) && (num_col_tiles != '0) && (num_k_tiles != '0);

   tile_addr_gen #(
      .SYS_ARR_DIM (SYS_ARR_DIM),
      .ADDR_W      (ADDR_W),
      .ROWS_W      (ROWS_W),
      .CT_W        (CT_W),
      .KT_W        (KT_W),
      .COL_W       (COL_W)
   ) u_addr_gen (
      .clk              (clk),
      .reset            (reset),
      .clear            (gen_clear),
      .advance          (advance),
      .num_rows         (calc_num_rows),
      .num_col_tiles    (cfg_col_tiles),
      .num_k_tiles      (cfg_k_tiles),
      .base_weight      (cfg_base_weight),
      .base_data        (cfg_base_data),
      .next_weight_addr (next_weight_addr),
      .cur_data_addr    (cur_data_addr),
      .cur_col          (cur_col),
      .cur_add          (cur_add),
      .has_next         (has_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= S_IDLE;
         cfg_prefetch       <= 1'b0;
         cfg_col_tiles      <= '0;
         cfg_k_tiles        <= '0;
         cfg_base_weight    <= '0;
         cfg_base_data      <= '0;
         pf_issued          <= 1'b0;
         pf_done            <= 1'b0;
         weight_mem_fifo_en <= 1'b0;
         weight_fifo_arr_en <= 1'b0;
         data_mem_calc_en   <= 1'b0;
         weight_addr        <= '0;
         data_addr          <= '0;
         calc_num_rows      <= '0;
         accum_submat_col   <= '0;
         accum_add          <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cfg_prefetch    <= prefetch;
                  cfg_col_tiles   <= num_col_tiles;
                  cfg_k_tiles     <= num_k_tiles;
                  cfg_base_weight <= base_weight;
                  cfg_base_data   <= base_data;
                  calc_num_rows   <= num_rows;
                  if (counts_ok) begin
                     // tile (0,0) sits at the base, so the live input is used directly
                     state              <= S_W_LOAD;
                     busy               <= 1'b1;
                     weight_mem_fifo_en <= 1'b1;
                     weight_addr        <= base_weight;
                  end else begin
                     state <= S_FINISH;
                  end
               end
            end
            S_W_LOAD: begin
               if (weight_mem_fifo_en && weight_mem_fifo_done) begin
                  weight_mem_fifo_en <= 1'b0;
                  weight_fifo_arr_en <= 1'b1;
                  state              <= S_W_XFER;
               end
            end
            S_W_XFER: begin
               if (weight_fifo_arr_en && weight_fifo_arr_done) begin
                  weight_fifo_arr_en <= 1'b0;
                  data_mem_calc_en   <= 1'b1;
                  data_addr          <= cur_data_addr;
                  accum_submat_col   <= cur_col;
                  accum_add          <= cur_add;
                  pf_issued          <= 1'b0;
                  pf_done            <= 1'b0;
                  state              <= S_CALC;
               end
            end
            S_CALC: begin
               if (pf_ack) begin
                  weight_mem_fifo_en <= 1'b0;
                  pf_done            <= 1'b1;
               end
               if (advance) begin
                  data_mem_calc_en <= 1'b0;
                  if (!has_next) begin
                     state <= S_FINISH;
                  end else if (!cfg_prefetch) begin
                     state              <= S_W_LOAD;
                     weight_mem_fifo_en <= 1'b1;
                     weight_addr        <= next_weight_addr;
                  end else if (pf_done || pf_ack) begin
                     state              <= S_W_XFER;
                     weight_fifo_arr_en <= 1'b1;
                  end else begin
                     // calc beat the prefetch; launch it now if it never got issued
                     state <= S_DRAIN;
                     if (!pf_issued) begin
                        weight_mem_fifo_en <= 1'b1;
                        weight_addr        <= next_weight_addr;
                        pf_issued          <= 1'b1;
                     end
                  end
               end else if (cfg_prefetch && has_next && !pf_issued) begin
                  weight_mem_fifo_en <= 1'b1;
                  weight_addr        <= next_weight_addr;
                  pf_issued          <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (weight_mem_fifo_en && weight_mem_fifo_done) begin
                  weight_mem_fifo_en <= 1'b0;
                  weight_fifo_arr_en <= 1'b1;
                  state              <= S_W_XFER;
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
